// File: rtl/sdram_responder.sv
// sdram_responder: chip-side stand-in for a 16-bit single-word SDRAM. Decodes controller
// commands, serves reads from on-chip RAM at CAS latency 2 or 3, and latches protocol errors.
module sdram_responder #(
    parameter int AW   = 12,
    parameter int TRCD = 2
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        SDRAM_CKE,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic [12:0] SDRAM_A,
    input  logic [1:0]  SDRAM_BA,
    input  logic        SDRAM_DQML,
    input  logic        SDRAM_DQMH,
    inout  wire  [15:0] SDRAM_DQ,
    output logic [6:0]  err,
    output logic        mode_valid,
    output logic [3:0]  bank_open,
    output logic [15:0] refresh_count
);
    localparam int CW = $clog2(TRCD + 1);

    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;

    logic [3:0]    cmd;
    logic          is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
    logic          bad_mode, trcd_short;
    logic [12:0]   row_q [4];
    logic [CW-1:0] trcd_cnt [4];
    logic [2:0]    cl_q;
    logic [23:0]   idx_full;
    logic [AW-1:0] idx;
    logic          unused_idx_hi;
    logic [15:0]   mem [2**AW];

    logic          rd_vld_p0, rd_vld_p1, dq_oe_p2;
    logic [AW-1:0] rd_idx_p0, rd_idx_p1;
    logic          rd_sel_vld;
    logic [AW-1:0] rd_sel_idx;
    logic [15:0]   dq_q_p2;

    assign cmd    = {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
    assign is_act = SDRAM_CKE && (cmd == CMD_ACTIVE);
    assign is_rd  = SDRAM_CKE && (cmd == CMD_READ);
    assign is_wr  = SDRAM_CKE && (cmd == CMD_WRITE);
    assign is_pre = SDRAM_CKE && (cmd == CMD_PRECHARGE);
    assign is_ref = SDRAM_CKE && (cmd == CMD_REFRESH);
    assign is_lmr = SDRAM_CKE && (cmd == CMD_LOAD_MODE);

    // Full word index is {bank, row, column}; only the low AW bits exist in the array.
    assign idx_full      = {SDRAM_BA, row_q[SDRAM_BA], SDRAM_A[8:0]};
    assign idx           = idx_full[AW-1:0];
    assign unused_idx_hi = ^idx_full[23:AW];

    assign trcd_short = trcd_cnt[SDRAM_BA] < CW'(TRCD);
    assign bad_mode   = !((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3)) ||
                        (SDRAM_A[2:0] != 3'd0);

    assign rd_sel_vld = (cl_q == 3'd3) ? rd_vld_p1 : rd_vld_p0;
    assign rd_sel_idx = (cl_q == 3'd3) ? rd_idx_p1 : rd_idx_p0;

    assign SDRAM_DQ = dq_oe_p2 ? dq_q_p2 : 16'bz;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            err           <= '0;
            mode_valid    <= 1'b0;
            cl_q          <= 3'd2;
            bank_open     <= '0;
            refresh_count <= '0;
            rd_vld_p0     <= 1'b0;
            rd_vld_p1     <= 1'b0;
            dq_oe_p2      <= 1'b0;
            for (int b = 0; b < 4; b++) trcd_cnt[b] <= CW'(TRCD);
        end else begin
            for (int b = 0; b < 4; b++)
                if (trcd_cnt[b] < CW'(TRCD)) trcd_cnt[b] <= trcd_cnt[b] + CW'(1);

            // p0: read accepted; p1: one cycle old; p2: DQ drive slot
            rd_vld_p0 <= is_rd;
            rd_vld_p1 <= rd_vld_p0;
            dq_oe_p2  <= rd_sel_vld && !is_wr;
            if (rd_sel_vld && is_wr) err[6] <= 1'b1;

            if (is_act) begin
                if (bank_open[SDRAM_BA]) err[1] <= 1'b1;
                bank_open[SDRAM_BA] <= 1'b1;
                trcd_cnt[SDRAM_BA]  <= CW'(1);
            end
            if (is_rd || is_wr) begin
                if (!bank_open[SDRAM_BA]) err[0] <= 1'b1;
                if (trcd_short)           err[2] <= 1'b1;
                if (!mode_valid)          err[4] <= 1'b1;
                if (SDRAM_A[10])          bank_open[SDRAM_BA] <= 1'b0;
            end
            if (is_pre) begin
                if (SDRAM_A[10]) bank_open <= '0;
                else             bank_open[SDRAM_BA] <= 1'b0;
            end
            if (is_ref) begin
                refresh_count <= refresh_count + 16'd1;
                if (|bank_open) err[3] <= 1'b1;
            end
            if (is_lmr) begin
                mode_valid <= 1'b1;
                if (bad_mode) begin
                    err[5] <= 1'b1;
                    cl_q   <= 3'd2;
                end else begin
                    cl_q   <= SDRAM_A[6:4];
                end
            end
        end
    end

    // Data path carries no reset: rows, read indices, DQ register and array contents.
    always_ff @(posedge clk) begin
        if (is_act) row_q[SDRAM_BA] <= SDRAM_A;
        rd_idx_p0 <= idx;
        rd_idx_p1 <= rd_idx_p0;
        dq_q_p2   <= mem[rd_sel_idx];
        if (is_wr && !SDRAM_DQML) mem[idx][7:0]  <= SDRAM_DQ[7:0];
        if (is_wr && !SDRAM_DQMH) mem[idx][15:8] <= SDRAM_DQ[15:8];
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Randomized bench for sdram_responder: a time-indexed reference model of the SDRAM
// command rules predicts flags, counters and the DQ drive slot every cycle.
module tb_sdram_responder;
    localparam logic [3:0] C_LMR = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010, C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100, C_RD  = 4'b0101, C_BST = 4'b0110, C_NOP = 4'b0111;
    localparam logic [15:0] IDLE = 16'hFFFF;

    logic        clk = 1'b0;
    logic        init_n, cke, ncs, nras, ncas, nwe, dqml, dqmh;
    logic [12:0] a;
    logic [1:0]  ba;
    logic [15:0] dq_drv;
    logic        dq_drv_en;
    tri1  [15:0] dq_bus;
    logic [6:0]  err;
    logic        mode_valid;
    logic [3:0]  bank_open;
    logic [15:0] refresh_count;

    always #5 clk = ~clk;
    assign dq_bus = dq_drv_en ? dq_drv : 16'bz;

    sdram_responder #(.AW(12), .TRCD(2)) dut (
        .clk(clk), .init_n(init_n), .SDRAM_CKE(cke),
        .SDRAM_nCS(ncs), .SDRAM_nRAS(nras), .SDRAM_nCAS(ncas), .SDRAM_nWE(nwe),
        .SDRAM_A(a), .SDRAM_BA(ba), .SDRAM_DQML(dqml), .SDRAM_DQMH(dqmh),
        .SDRAM_DQ(dq_bus), .err(err), .mode_valid(mode_valid),
        .bank_open(bank_open), .refresh_count(refresh_count)
    );

    // Reference model state
    typedef struct { int due; int idx; } rd_t;
    rd_t         pend[$];
    logic [15:0] m_mem [4096];
    logic [1:0]  m_known [4096];
    logic [12:0] m_row [4];
    int          m_last_act [4];
    logic [3:0]  m_open;
    logic [6:0]  m_err;
    logic        m_mode;
    int          m_cl;
    logic [15:0] m_ref;
    logic        m_dq_en, m_dq_known;
    logic [15:0] m_dq;
    int          cyc = 0;
    int          n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_err = '0; m_mode = 1'b0; m_cl = 2; m_open = '0; m_ref = '0;
        pend.delete();
        m_dq_en = 1'b0; m_dq_known = 1'b0; m_dq = IDLE;
        for (int b = 0; b < 4; b++) m_last_act[b] = -1000;
    endtask

    task automatic model_edge();
        logic [3:0] c;
        logic       wr;
        int         idx;
        rd_t        e;
        c  = {ncs, nras, ncas, nwe};
        wr = cke && (c == C_WR);
        m_dq_en = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            if (wr) m_err[6] = 1'b1;
            else begin
                m_dq_en    = 1'b1;
                m_dq       = m_mem[e.idx];
                m_dq_known = (m_known[e.idx] == 2'b11);
            end
        end
        if (!cke) return;
        idx = (int'(ba) * (1 << 22) + int'(m_row[ba]) * 512 + int'(a[8:0])) % 4096;
        case (c)
            C_ACT: begin
                if (m_open[ba]) m_err[1] = 1'b1;
                m_open[ba] = 1'b1; m_row[ba] = a; m_last_act[ba] = cyc;
            end
            C_RD, C_WR: begin
                if (!m_open[ba]) m_err[0] = 1'b1;
                if (cyc - m_last_act[ba] < 2) m_err[2] = 1'b1;
                if (!m_mode) m_err[4] = 1'b1;
                if (a[10]) m_open[ba] = 1'b0;
                if (c == C_RD) pend.push_back('{cyc + m_cl - 1, idx});
                else begin
                    if (!dqml) begin m_mem[idx][7:0]  = dq_drv[7:0];  m_known[idx][0] = 1'b1; end
                    if (!dqmh) begin m_mem[idx][15:8] = dq_drv[15:8]; m_known[idx][1] = 1'b1; end
                end
            end
            C_PRE: if (a[10]) m_open = '0; else m_open[ba] = 1'b0;
            C_REF: begin
                m_ref = m_ref + 16'd1;
                if (m_open != 0) m_err[3] = 1'b1;
            end
            C_LMR: begin
                m_mode = 1'b1;
                if (!(a[6:4] == 3'd2 || a[6:4] == 3'd3) || a[2:0] != 3'd0) begin
                    m_err[5] = 1'b1; m_cl = 2;
                end else m_cl = int'(a[6:4]);
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        check("err", err, m_err);
        check("bank_open", bank_open, m_open);
        check("refresh_count", refresh_count, m_ref);
        check("mode_valid", mode_valid, m_mode);
        if (!m_dq_en)        check("dq_idle", dq_bus, IDLE);
        else if (m_dq_known) check("dq_data", dq_bus, m_dq);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (init_n) model_edge();
        #1 dq_drv_en = 1'b0;
        #1 check_outputs();
    endtask

    task automatic issue(input logic [3:0] c, input logic [12:0] aa = '0, input logic [1:0] bb = '0,
                         input logic [15:0] d = '0, input logic ml = 1'b0, input logic mh = 1'b0,
                         input logic ck = 1'b1);
        {ncs, nras, ncas, nwe} = c;
        a = aa; ba = bb; dq_drv = d; dqml = ml; dqmh = mh; cke = ck;
        dq_drv_en = ck && (c == C_WR);
        step();
    endtask

    task automatic reset_pulse();
        init_n = 1'b0;
        model_reset();
        #1 check_outputs();
        step();
        init_n = 1'b1;
    endtask

    task automatic random_cmd();
        int          r;
        logic [12:0] aa;
        logic [15:0] d;
        r  = $urandom_range(0, 99);
        aa = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0), 1'b0, 9'($urandom_range(0, 7))};
        d  = 16'($urandom);
        if (d == IDLE) d = 16'h7FFF;
        if      (r < 30) issue(C_NOP);
        else if (r < 45) issue(C_RD, aa, 2'($urandom));
        else if (r < 60) begin
            if (m_dq_en) issue(C_NOP);
            else issue(C_WR, aa, 2'($urandom), d, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end
        else if (r < 72) issue(C_ACT, 13'($urandom_range(0, 7)), 2'($urandom));
        else if (r < 80) issue(C_PRE, {2'b0, 1'($urandom_range(0, 2) == 0), 10'd0}, 2'($urandom));
        else if (r < 83) issue(C_REF);
        else if (r < 88) issue({1'b1, 3'($urandom)}, aa, 2'($urandom));
        else if (r < 93) issue(4'($urandom), aa, 2'($urandom), d, 1'b0, 1'b0, 1'b0);
        else             issue(C_BST);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) m_known[i] = 2'b00;
        {ncs, nras, ncas, nwe} = C_NOP;
        a = '0; ba = '0; dqml = 1'b0; dqmh = 1'b0; cke = 1'b1; dq_drv = '0; dq_drv_en = 1'b0;
        init_n = 1'b0;
        model_reset();
        #1 check_outputs();
        repeat (3) step();
        init_n = 1'b1;
        repeat (2) issue(C_NOP);

        // Power-up init sequence
        issue(C_PRE, 13'h400);
        issue(C_REF);
        issue(C_REF);
        issue(C_LMR, 13'h220);
        check("init_mode_valid", mode_valid, 1);
        check("init_refresh_count", refresh_count, 2);
        check("init_err", err, 0);
        for (int b = 0; b < 4; b++) issue(C_ACT, 13'(b), 2'(b));
        issue(C_NOP);
        issue(C_PRE, 13'h400);

        // Full write then read-back at CL=2
        issue(C_ACT, 13'h0005, 2'd1);
        repeat (2) issue(C_NOP);
        issue(C_WR, 13'h003, 2'd1, 16'hA55A);
        repeat (3) issue(C_NOP);
        issue(C_RD, 13'h003, 2'd1);
        check("rd_cl2_T", dq_bus, IDLE);
        issue(C_NOP);
        check("rd_cl2_T1", dq_bus, 16'hA55A);
        issue(C_NOP);
        check("rd_cl2_T2", dq_bus, IDLE);

        // Upper-byte-only write
        issue(C_WR, 13'h003, 2'd1, 16'h1234, 1'b1, 1'b0);
        issue(C_NOP);
        issue(C_RD, 13'h003, 2'd1);
        issue(C_NOP);
        check("byte_write", dq_bus, 16'h125A);
        issue(C_NOP);

        // Back-to-back reads at CL=3
        issue(C_LMR, 13'h230);
        issue(C_WR, 13'h004, 2'd1, 16'h0F0F);
        issue(C_NOP);
        issue(C_RD, 13'h003, 2'd1);
        issue(C_RD, 13'h004, 2'd1);
        check("b2b_T1", dq_bus, IDLE);
        issue(C_NOP);
        check("b2b_T2", dq_bus, 16'h125A);
        issue(C_NOP);
        check("b2b_T3", dq_bus, 16'h0F0F);
        issue(C_NOP);
        check("b2b_T4", dq_bus, IDLE);
        check("clean_err", err, 0);

        // Protocol violations stay sticky until reset
        issue(C_RD, 13'h000, 2'd0);
        check("closed_bank_err", err[0], 1);
        issue(C_ACT, 13'h000, 2'd2);
        issue(C_RD, 13'h001, 2'd2);
        check("trcd_err", err[2], 1);
        issue(C_REF);
        check("refresh_open_err", err, 7'h0D);
        repeat (4) issue(C_NOP);
        issue(C_LMR, 13'h250);
        check("bad_mode_err", err, 7'h2D);
        repeat (3) issue(C_NOP);
        check("sticky_err", err, 7'h2D);
        reset_pulse();
        check("err_after_reset", err, 0);

        // Reset right after a READ drops the data slot
        issue(C_LMR, 13'h220);
        issue(C_ACT, 13'h0005, 2'd1);
        repeat (2) issue(C_NOP);
        issue(C_RD, 13'h003, 2'd1);
        init_n = 1'b0;
        model_reset();
        #1 check_outputs();
        repeat (2) begin
            step();
            check("rst_rd_dq", dq_bus, IDLE);
        end
        check("rst_rd_bank_open", bank_open, 0);
        init_n = 1'b1;
        issue(C_NOP);

        // Write landing on a scheduled read drive
        issue(C_LMR, 13'h220);
        issue(C_ACT, 13'h0005, 2'd1);
        repeat (2) issue(C_NOP);
        issue(C_RD, 13'h003, 2'd1);
        issue(C_WR, 13'h005, 2'd1, 16'h3C3C);
        check("wr_cancel_dq", dq_bus, IDLE);
        check("wr_cancel_err", err, 7'h40);
        repeat (2) issue(C_NOP);

        // Randomized rounds
        for (int round = 0; round < 3; round++) begin
            reset_pulse();
            issue(C_LMR, (round % 2 == 0) ? 13'h220 : 13'h230);
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    reset_pulse();
                    issue(C_LMR, (round % 2 == 0) ? 13'h220 : 13'h230);
                end else random_cmd();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
